// File: rtl/edge_align_pkg.sv
// Shared types and constants for the launch/latch edge alignment calibration controller.
package edge_align_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CHECK,
      EVAL,
      LOCKED,
      FAIL
   } state_t;

   localparam int         NUM_COMBO   = 4;
   localparam logic [1:0] RESET_COMBO = 2'b01;
   localparam logic [1:0] LAST_COMBO  = 2'(NUM_COMBO - 1);

   // Combo bit 1 selects the launch edge, bit 0 the latch edge (1 = posedge).
   function automatic logic launch_edge(input logic [1:0] combo);
      return combo[1];
   endfunction

   function automatic logic latch_edge(input logic [1:0] combo);
      return combo[0];
   endfunction

endpackage

// File: rtl/edge_align_errcnt.sv
// Saturating mismatch counter: compares two WIDTH-bit words per cycle, synchronous clear wins over enable.
module edge_align_errcnt #(
   parameter int WIDTH = 1,
   parameter int CNTW  = 8
) (
   input  logic             launchclk,
   input  logic             clr_i,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] rx_dat_i,
   input  logic [WIDTH-1:0] exp_dat_i,
   output logic [CNTW-1:0]  cnt_o
);

   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            mis;

   assign mis   = |(rx_dat_i ^ exp_dat_i);
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (en_i && mis && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge launchclk or posedge clr_i) begin
      if (clr_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/edge_align_ctrl.sv
// Sweeps the four launch/latch edge combinations, locks the first error-free one or falls back to the best.
// Define EDGE_ALIGN_RECAL_EN to keep monitoring while LOCKED and re-sweep automatically on errors.
module edge_align_ctrl
   import edge_align_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int SETTLE_CYC = 4,
   parameter int WINDOW     = 16,
   parameter int CNTW       = 8
) (
   input  logic             launchclk,
   input  logic             clr_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] rx_dat_i,
   input  logic [WIDTH-1:0] exp_dat_i,
   output logic             launchedge_o,
   output logic             latchedge_o,
   output logic             busy_o,
   output logic             locked_o,
   output logic             fail_o,
   output logic [CNTW-1:0]  err_cnt_o
);

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
   localparam logic [15:0] WIN_LAST    = 16'(WINDOW - 1);

   state_t          state_q, state_d;
   logic [1:0]      c_q, c_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      best_c_q, best_c_d;
   logic [CNTW-1:0] best_cnt_q, best_cnt_d;
   logic [CNTW-1:0] err_out_q, err_out_d;
   logic [15:0]     cyc_q, cyc_d;
   logic            busy_q, busy_d;
   logic            locked_q, locked_d;
   logic            fail_q, fail_d;
   logic            err_clear, err_en, restart;
   logic [CNTW-1:0] err_cnt;

   edge_align_errcnt #(.WIDTH(WIDTH), .CNTW(CNTW)) u_errcnt (
      .launchclk (launchclk),
      .clr_i     (clr_i),
      .clear_i   (err_clear),
      .en_i      (err_en),
      .rx_dat_i  (rx_dat_i),
      .exp_dat_i (exp_dat_i),
      .cnt_o     (err_cnt)
   );

`ifdef EDGE_ALIGN_RECAL_EN
   // The last sample of a monitor block is not yet in the counter, so fold it in here.
   logic blk_err;
   assign blk_err = (err_cnt != '0) || (rx_dat_i != exp_dat_i);
`endif

   always_comb begin
      state_d    = state_q;
      c_d        = c_q;
      sel_d      = sel_q;
      best_c_d   = best_c_q;
      best_cnt_d = best_cnt_q;
      err_out_d  = err_out_q;
      cyc_d      = cyc_q;
      busy_d     = busy_q;
      locked_d   = locked_q;
      fail_d     = fail_q;
      err_clear  = 1'b0;
      err_en     = 1'b0;
      restart    = 1'b0;

      case (state_q)
         IDLE: restart = start_i;
         SETTLE: begin
            err_clear = 1'b1;
            if (cyc_q == SETTLE_LAST) begin
               state_d = CHECK;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         CHECK: begin
            err_en = 1'b1;
            if (cyc_q == WIN_LAST) begin
               state_d = EVAL;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         EVAL: begin
            err_clear = 1'b1;
            err_out_d = err_cnt;
            if ((c_q == 2'd0) || (err_cnt < best_cnt_q)) begin
               best_c_d   = c_q;
               best_cnt_d = err_cnt;
            end
            if (err_cnt == '0) begin
               state_d  = LOCKED;
               busy_d   = 1'b0;
               locked_d = 1'b1;
            end else if (c_q != LAST_COMBO) begin
               state_d = SETTLE;
               c_d     = c_q + 2'd1;
               sel_d   = c_q + 2'd1;
            end else begin
               state_d   = FAIL;
               busy_d    = 1'b0;
               fail_d    = 1'b1;
               sel_d     = best_c_d;
               err_out_d = best_cnt_d;
            end
         end
         LOCKED: begin
            restart = start_i;
`ifdef EDGE_ALIGN_RECAL_EN
            err_en = 1'b1;
            if (cyc_q == WIN_LAST) begin
               cyc_d     = '0;
               err_clear = 1'b1;
               if (blk_err) begin
                  state_d  = SETTLE;
                  c_d      = 2'd0;
                  sel_d    = 2'd0;
                  busy_d   = 1'b1;
                  locked_d = 1'b0;
               end
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
`endif
         end
         FAIL: restart = start_i;
         default: state_d = IDLE;
      endcase

      if (restart) begin
         state_d  = SETTLE;
         c_d      = 2'd0;
         sel_d    = 2'd0;
         cyc_d    = '0;
         busy_d   = 1'b1;
         locked_d = 1'b0;
         fail_d   = 1'b0;
      end
   end

   always_ff @(posedge launchclk or posedge clr_i) begin
      if (clr_i) begin
         state_q    <= IDLE;
         c_q        <= 2'd0;
         sel_q      <= RESET_COMBO;
         best_c_q   <= 2'd0;
         best_cnt_q <= '0;
         err_out_q  <= '0;
         cyc_q      <= '0;
         busy_q     <= 1'b0;
         locked_q   <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         c_q        <= c_d;
         sel_q      <= sel_d;
         best_c_q   <= best_c_d;
         best_cnt_q <= best_cnt_d;
         err_out_q  <= err_out_d;
         cyc_q      <= cyc_d;
         busy_q     <= busy_d;
         locked_q   <= locked_d;
         fail_q     <= fail_d;
      end
   end

   assign launchedge_o = launch_edge(sel_q);
   assign latchedge_o  = latch_edge(sel_q);
   assign busy_o       = busy_q;
   assign locked_o     = locked_q;
   assign fail_o       = fail_q;
   assign err_cnt_o    = err_out_q;

endmodule

// File: tb/tb_edge_align_ctrl.sv
// Randomized self-checking bench for edge_align_ctrl against a window-sum reference model.
// Define EDGE_ALIGN_RECAL_EN to also exercise the locked-state re-calibration.
module tb_edge_align_ctrl;

   logic       launchclk = 1'b0;
   logic       clr = 1'b1;
   logic       start = 1'b0;
   logic       rx = 1'b0, ex = 1'b0;
   logic       l, t, busy, locked, fail;
   logic [7:0] errc;

   logic       start2 = 1'b0;
   logic [3:0] rx2 = 4'd0, ex2 = 4'd0;
   logic       l2, t2, busy2, locked2, fail2;
   logic [3:0] errc2;

   int checks = 0;
   int failures = 0;
   int mism[0:84];
   int errs[4];

   always #5 launchclk = ~launchclk;

   edge_align_ctrl dut (
      .launchclk(launchclk), .clr_i(clr), .start_i(start), .rx_dat_i(rx), .exp_dat_i(ex),
      .launchedge_o(l), .latchedge_o(t), .busy_o(busy), .locked_o(locked), .fail_o(fail),
      .err_cnt_o(errc)
   );

   // Small-counter instance: 4-bit data and a window longer than the counter range.
   edge_align_ctrl #(.WIDTH(4), .SETTLE_CYC(2), .WINDOW(20), .CNTW(4)) dut_sat (
      .launchclk(launchclk), .clr_i(clr), .start_i(start2), .rx_dat_i(rx2), .exp_dat_i(ex2),
      .launchedge_o(l2), .latchedge_o(t2), .busy_o(busy2), .locked_o(locked2), .fail_o(fail2),
      .err_cnt_o(errc2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int m);
      ex = 1'($urandom);
      rx = ex ^ 1'(m);
   endtask

   task automatic tick();
      @(posedge launchclk);
      #1;
   endtask

   // e<n>: exact mismatch count inside combo n's compare window, or -1 for random traffic.
   task automatic run_sweep(input int e0, input int e1, input int e2, input int e3, input int restart_edge);
      int req[4];
      int k, last, best, sum, off, rate;
      logic [4:0] fin;
      req = '{e0, e1, e2, e3};
      for (int e = 0; e <= 84; e++) mism[e] = int'($urandom_range(0, 1));
      for (int c = 0; c < 4; c++) begin
         off  = int'($urandom_range(0, 15));
         rate = int'($urandom_range(0, 2));
         for (int p = 0; p < 16; p++) begin
            if (req[c] < 0)
               mism[21*c+5+p] = (rate != 0 && int'($urandom_range(0, 3)) < rate) ? 1 : 0;
            else
               mism[21*c+5+p] = (((p + off) % 16) < req[c]) ? 1 : 0;
         end
      end
      k = -1;
      for (int c = 0; c < 4; c++) begin
         sum = 0;
         for (int p = 0; p < 16; p++) sum += mism[21*c+5+p];
         errs[c] = (sum > 255) ? 255 : sum;
         if (k < 0 && errs[c] == 0) k = c;
      end
      best = 0;
      for (int c = 1; c < 4; c++) if (errs[c] < errs[best]) best = c;
      last = (k >= 0) ? 21 * (k + 1) : 84;

      start = 1'b1;
      drive(0);
      tick();
      start = 1'b0;
      check("start", 32'({busy, locked, fail, l, t}), 32'b10000);
      for (int e = 1; e <= last; e++) begin
         drive(mism[e]);
         start = (e == restart_edge);
         tick();
         start = 1'b0;
         if (e < last) check("busy", 32'({busy, locked, fail}), 32'b100);
         if (e % 21 == 0 && e < last) begin
            check("eval_err", 32'(errc), 32'(errs[e/21-1]));
            check("next_sel", 32'({l, t}), 32'(e / 21));
         end
      end
      if (k >= 0) begin
         check("lock_flags", 32'({busy, locked, fail}), 32'b010);
         check("lock_sel", 32'({l, t}), 32'(k));
         check("lock_err", 32'(errc), 32'd0);
         fin = {3'b010, 2'(k)};
      end else begin
         check("fail_flags", 32'({busy, locked, fail}), 32'b001);
         check("fail_sel", 32'({l, t}), 32'(best));
         check("fail_err", 32'(errc), 32'(errs[best]));
         fin = {3'b001, 2'(best)};
      end
      $display("sweep errs=%0d,%0d,%0d,%0d restart_at=%0d -> %s combo=%0d at edge %0d",
               errs[0], errs[1], errs[2], errs[3], restart_edge,
               (k >= 0) ? "locked" : "fail", (k >= 0) ? k : best, last);
      for (int i = 0; i < 5; i++) begin
         rx = ex;
         tick();
         check("hold", 32'({busy, locked, fail, l, t}), 32'(fin));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check(tag, 32'({busy, locked, fail, l, t}), 32'b00001);
      check({tag, "_err"}, 32'(errc), 32'd0);
   endtask

   initial begin
      drive(0);
      repeat (3) @(posedge launchclk);
      #1 clr = 1'b0;
      tick();
      check_reset_vals("reset");
      check("reset_sat", 32'({busy2, locked2, fail2, l2, t2, errc2}), 32'b00001_0000);

      run_sweep(0, 0, 0, 0, 10);
      run_sweep(4, 7, 0, 0, 0);
      run_sweep(5, 3, 3, 16, 0);

      // Abort mid-sweep; the controller must come back in IDLE and stay there.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         drive(1);
         tick();
      end
      #2 clr = 1'b1;
      #1;
      check_reset_vals("abort");
      tick();
      clr = 1'b0;
      for (int i = 0; i < 25; i++) begin
         drive(1);
         tick();
         check("abort_idle", 32'({busy, locked, fail, l, t}), 32'b00001);
      end
      $display("abort at edge 30 -> idle");

      for (int n = 0; n < 8; n++) run_sweep(-1, -1, -1, -1, int'($urandom_range(1, 20)));

      // Every cycle mismatches on some bit: each window saturates at 15, ties keep combo 0.
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int e = 1; e <= 92; e++) begin
         ex2 = 4'($urandom);
         rx2 = ex2 ^ 4'($urandom_range(1, 15));
         tick();
         if (e < 92) check("sat_busy", 32'({busy2, locked2, fail2}), 32'b100);
         if (e == 23) check("sat_eval", 32'({errc2, l2, t2}), 32'b1111_01);
      end
      check("sat_fail", 32'({busy2, locked2, fail2, l2, t2}), 32'b00100);
      check("sat_err", 32'(errc2), 32'd15);
      $display("saturation sweep -> fail combo=0 err=%0d", errc2);

`ifdef EDGE_ALIGN_RECAL_EN
      run_sweep(0, 0, 0, 0, 0);
      for (int e = 27; e <= 37; e++) begin
         drive((e == 30) ? 1 : 0);
         tick();
         if (e < 37) check("recal_hold", 32'({busy, locked, fail}), 32'b010);
      end
      check("recal_drop", 32'({busy, locked, fail, l, t}), 32'b10000);
      $display("recal: error at edge 30 -> re-sweep at edge 37");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
